lock_controller: RTL and testbench

LOCK_CONTROLLER -- requirements
Module: lock_controller

---
 rtl/lock_pkg.sv | 19 +
 rtl/gate_timer.sv | 34 +++
 rtl/lock_controller.sv | 186 ++++++++++++++++++
 tb/tb_lock_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the canal lock controller.
// Holds the controller FSM state type and the default water-level and timing constants.
package lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_GATE
  } state_e;

  localparam int unsigned DefaultWidth      = 8;
  localparam int unsigned DefaultInnerLevel = 49;
  localparam int unsigned DefaultOuterLevel = 73;
  localparam int unsigned DefaultFillStep   = 4;
  localparam int unsigned DefaultDrainStep  = 5;
  localparam int unsigned DefaultGateCycles = 4;

endpackage

// File: rtl/gate_timer.sv
// Gate-movement timer: loads GATE_CYCLES, counts down while enabled and pulses expire
// in the last cycle of the move.
// Ports:
//   clk, rst  - clock and asynchronous active-low reset
//   load      - reload the counter with GATE_CYCLES
//   en        - count down this cycle
//   expire    - high during the final counted cycle (count == 1 while enabled)
module gate_timer #(
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned CntW = $clog2(GATE_CYCLES + 1);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= CntW'(GATE_CYCLES);
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - CntW'(1);
    end
  end

  assign expire = en && (count_q == CntW'(1));

endmodule

// File: rtl/lock_controller.sv
// Canal lock controller: raises/lowers the lock level between the inner and outer canal
// levels, sequences the two ports and tracks gondola occupancy.
// Ports:
//   clk, rst                  - clock and asynchronous active-low reset
//   fill_req, drain_req       - level requests (raise / lower)
//   outer_close, inner_close  - requested port states, 1 = closed
//   gondola_in, gondola_out   - one-cycle gondola entry / exit pulses
//   lock_level                - current lock water level
//   outer_closed, inner_closed- actual port states, 1 = closed
//   occupied                  - gondola inside the lock
//   busy                      - FSM not idle
//   done, err                 - one-cycle completion / rejection pulses
module lock_controller
  import lock_pkg::*;
#(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned INNER_LEVEL = DefaultInnerLevel,
  parameter int unsigned OUTER_LEVEL = DefaultOuterLevel,
  parameter int unsigned FILL_STEP   = DefaultFillStep,
  parameter int unsigned DRAIN_STEP  = DefaultDrainStep,
  parameter int unsigned GATE_CYCLES = DefaultGateCycles,
  parameter int unsigned RESET_LEVEL = INNER_LEVEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill_req,
  input  logic             drain_req,
  input  logic             outer_close,
  input  logic             inner_close,
  input  logic             gondola_in,
  input  logic             gondola_out,
  output logic [WIDTH-1:0] lock_level,
  output logic             outer_closed,
  output logic             inner_closed,
  output logic             occupied,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // One extra bit so a step past either limit never wraps before clamping.
  localparam logic [WIDTH:0] InnerW = (WIDTH + 1)'(INNER_LEVEL);
  localparam logic [WIDTH:0] OuterW = (WIDTH + 1)'(OUTER_LEVEL);
  localparam logic [WIDTH:0] FillW  = (WIDTH + 1)'(FILL_STEP);
  localparam logic [WIDTH:0] DrainW = (WIDTH + 1)'(DRAIN_STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic             outer_closed_q, outer_closed_d;
  logic             inner_closed_q, inner_closed_d;
  logic             occupied_q, occupied_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             gate_sel_q, gate_sel_d;  // 0 = outer port moving, 1 = inner port moving
  logic             timer_load, timer_expire;
  logic [WIDTH:0]   level_w, fill_sum, drain_diff, fill_next, drain_next;
  logic             at_outer, at_inner, port_open;

  gate_timer #(
    .GATE_CYCLES(GATE_CYCLES)
  ) u_gate_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .en    (state_q == ST_GATE),
    .expire(timer_expire)
  );

  always_comb begin
    level_w    = {1'b0, level_q};
    fill_sum   = level_w + FillW;
    drain_diff = level_w - DrainW;
    fill_next  = (fill_sum >= OuterW) ? OuterW : fill_sum;
    // A borrow sets the top bit, which also means we went below the inner level.
    drain_next = (drain_diff[WIDTH] || (drain_diff <= InnerW)) ? InnerW : drain_diff;
    at_outer   = (level_w == OuterW);
    at_inner   = (level_w == InnerW);
    port_open  = !outer_closed_q || !inner_closed_q;
  end

  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    outer_closed_d = outer_closed_q;
    inner_closed_d = inner_closed_q;
    occupied_d     = occupied_q;
    gate_sel_d     = gate_sel_q;
    done_d         = 1'b0;
    err_d          = 1'b0;
    timer_load     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (outer_close != outer_closed_q) begin
          if (outer_close || (at_outer && inner_closed_q)) begin
            state_d    = ST_GATE;
            gate_sel_d = 1'b0;
            timer_load = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (inner_close != inner_closed_q) begin
          if (inner_close || (at_inner && outer_closed_q)) begin
            state_d    = ST_GATE;
            gate_sel_d = 1'b1;
            timer_load = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (fill_req || drain_req) begin
          if ((fill_req && drain_req) || port_open) begin
            err_d = 1'b1;
          end else if (fill_req) begin
            if (at_outer) done_d = 1'b1;
            else          state_d = ST_FILL;
          end else begin
            if (at_inner) done_d = 1'b1;
            else          state_d = ST_DRAIN;
          end
        end
      end
      ST_FILL: begin
        level_d = fill_next[WIDTH-1:0];
        if (fill_next == OuterW) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        level_d = drain_next[WIDTH-1:0];
        if (drain_next == InnerW) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_GATE: begin
        if (timer_expire) begin
          if (gate_sel_q) inner_closed_d = !inner_closed_q;
          else            outer_closed_d = !outer_closed_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Occupancy tracking runs in every state; simultaneous in/out cancels out.
    if (gondola_in && !gondola_out) begin
      if (port_open) occupied_d = 1'b1;
      else           err_d      = 1'b1;
    end else if (gondola_out && !gondola_in) begin
      occupied_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      level_q        <= WIDTH'(RESET_LEVEL);
      outer_closed_q <= 1'b1;
      inner_closed_q <= 1'b1;
      occupied_q     <= 1'b0;
      gate_sel_q     <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      outer_closed_q <= outer_closed_d;
      inner_closed_q <= inner_closed_d;
      occupied_q     <= occupied_d;
      gate_sel_q     <= gate_sel_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign lock_level   = level_q;
  assign outer_closed = outer_closed_q;
  assign inner_closed = inner_closed_q;
  assign occupied     = occupied_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_lock_controller.sv
// Directed testbench for lock_controller with a scoreboard queue of expected outputs.
module tb_lock_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fill_req = 1'b0, drain_req = 1'b0;
  logic       outer_close = 1'b1, inner_close = 1'b1;
  logic       gondola_in = 1'b0, gondola_out = 1'b0;
  logic [7:0] lock_level;
  logic       outer_closed, inner_closed, occupied, busy, done, err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic [7:0] lvl;
    logic       oc, ic, occ, bsy, dn, er;
  } exp_t;

  exp_t sb[$];

  lock_controller dut (
    .clk         (clk),
    .rst         (rst),
    .fill_req    (fill_req),
    .drain_req   (drain_req),
    .outer_close (outer_close),
    .inner_close (inner_close),
    .gondola_in  (gondola_in),
    .gondola_out (gondola_out),
    .lock_level  (lock_level),
    .outer_closed(outer_closed),
    .inner_closed(inner_closed),
    .occupied    (occupied),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string field, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s %s observed %0d expected %0d", tag, field, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] lvl, input logic oc, input logic ic,
                      input logic occ, input logic bsy, input logic dn, input logic er);
    exp_t e;
    e.tag = tag; e.lvl = lvl; e.oc = oc; e.ic = ic;
    e.occ = occ; e.bsy = bsy; e.dn = dn; e.er = er;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard empty observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "lock_level",   lock_level,          e.lvl);
      cmp(e.tag, "outer_closed", {7'd0, outer_closed}, {7'd0, e.oc});
      cmp(e.tag, "inner_closed", {7'd0, inner_closed}, {7'd0, e.ic});
      cmp(e.tag, "occupied",     {7'd0, occupied},     {7'd0, e.occ});
      cmp(e.tag, "busy",         {7'd0, busy},         {7'd0, e.bsy});
      cmp(e.tag, "done",         {7'd0, done},         {7'd0, e.dn});
      cmp(e.tag, "err",          {7'd0, err},          {7'd0, e.er});
    end
  endtask

  // Queue the expectation for the next edge, advance one cycle, then check it.
  task automatic tick(input string tag, input logic [7:0] lvl, input logic oc, input logic ic,
                      input logic occ, input logic bsy, input logic dn, input logic er);
    push(tag, lvl, oc, ic, occ, bsy, dn, er);
    @(posedge clk);
    #1;
    sample();
  endtask

  // Gate move accepted at the first edge, port toggles GATE_CYCLES (4) edges later.
  task automatic gate_move(input string tag, input logic [7:0] lvl, input logic oc0,
                           input logic ic0, input logic oc1, input logic ic1, input logic occ);
    for (int i = 0; i < 4; i++) tick(tag, lvl, oc0, ic0, occ, 1'b1, 1'b0, 1'b0);
    tick(tag, lvl, oc1, ic1, occ, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic fill_up(input string tag);
    logic [7:0] lvl;
    fill_req = 1'b1;
    tick(tag, 8'd49, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    fill_req = 1'b0;
    lvl = 8'd49;
    for (int i = 0; i < 6; i++) begin
      lvl = lvl + 8'd4;
      if (lvl < 8'd73) tick(tag, lvl, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      else             tick(tag, 8'd73, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic drain_down(input string tag);
    logic [7:0] exp_seq [5];
    exp_seq = '{8'd68, 8'd63, 8'd58, 8'd53, 8'd49};
    drain_req = 1'b1;
    tick(tag, 8'd73, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drain_req = 1'b0;
    for (int i = 0; i < 4; i++) tick(tag, exp_seq[i], 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(tag, exp_seq[4], 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    push("reset", 8'd49, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    rst = 1'b1;
    tick("idle", 8'd49, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill 49 -> 73, then drain 73 -> 49 with clamping
    fill_up("fill");
    tick("fill_after", 8'd73, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    fill_req = 1'b1;
    tick("fill_at_top", 8'd73, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    fill_req = 1'b0;
    drain_down("drain");
    tick("drain_after", 8'd49, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Rejections at the inner level
    outer_close = 1'b0;
    tick("outer_open_low", 8'd49, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    outer_close = 1'b1;
    fill_req = 1'b1; drain_req = 1'b1;
    tick("fill_and_drain", 8'd49, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    fill_req = 1'b0;
    tick("drain_at_bottom", 8'd49, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drain_req = 1'b0;
    gondola_in = 1'b1;
    tick("gondola_closed", 8'd49, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    gondola_in = 1'b0;

    // Open inner port; a drain pulse during the move is ignored
    inner_close = 1'b0;
    tick("inner_open", 8'd49, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drain_req = 1'b1;
    tick("inner_open", 8'd49, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drain_req = 1'b0;
    tick("inner_open", 8'd49, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick("inner_open", 8'd49, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick("inner_open", 8'd49, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    gondola_in = 1'b1;
    tick("gondola_in_open", 8'd49, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    gondola_in = 1'b0;
    fill_req = 1'b1;
    tick("fill_port_open", 8'd49, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    fill_req = 1'b0;
    inner_close = 1'b1;
    gate_move("inner_close", 8'd49, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    gondola_in = 1'b1; gondola_out = 1'b1;
    tick("gondola_both", 8'd49, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    gondola_in = 1'b0;
    tick("gondola_out", 8'd49, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    gondola_out = 1'b0;

    // Open outer port at the top, then fill is rejected
    fill_up("fill2");
    outer_close = 1'b0;
    gate_move("outer_open", 8'd73, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    fill_req = 1'b1;
    tick("fill_outer_open", 8'd73, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    fill_req = 1'b0;
    inner_close = 1'b0;
    tick("inner_open_outer_open", 8'd73, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    inner_close = 1'b1;
    outer_close = 1'b1;
    gate_move("outer_close", 8'd73, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset asserted mid-fill at 61
    drain_down("drain2");
    fill_req = 1'b1;
    tick("fill3", 8'd49, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    fill_req = 1'b0;
    tick("fill3", 8'd53, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick("fill3", 8'd57, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick("fill3", 8'd61, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    push("reset_mid_fill", 8'd49, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    tick("reset_hold", 8'd49, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick("after_reset", 8'd49, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
